majority_ckt: RTL and testbench

Five-input majority voter with structural combinational core and a registered output stage. Drives `z` high when at least three of the five inputs `x[4:0]` are 1. Used as a voting or redundancy primitive. Also offers a registered copy of the vote, the population count, and an optional saturating counter of majority events.

---
 rtl/majority_ckt_if.sv | 24 ++
 rtl/majority_ckt.sv | 80 ++++++++
 tb/tb_majority_ckt.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/majority_ckt_if.sv
// Signal bundle for the majority_ckt voter: voter inputs, combinational vote and
// population count, and the registered copies plus the majority-event counter.
interface majority_ckt_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       x;
    logic             in_valid;
    logic             z;
    logic [2:0]       ones;
    logic             z_q;
    logic [2:0]       ones_q;
    logic             out_valid;
    logic [CNT_W-1:0] maj_cnt;

    modport master (
        output x, in_valid,
        input  z, ones, z_q, ones_q, out_valid, maj_cnt
    );

    modport slave (
        input  x, in_valid,
        output z, ones, z_q, ones_q, out_valid, maj_cnt
    );
endinterface

// File: rtl/majority_ckt.sv
// Five-input majority voter: AND-OR vote, full-adder popcount, registered stage.
// Optional saturating majority-event counter enabled by `define MAJORITY_CNT_EN.
module majority_ckt #(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    majority_ckt_if.slave bus
);
    logic [4:0] w_x;
    logic [9:0] w_terms;
    logic       w_z;
    logic       w_fa1_s, w_fa1_c, w_fa2_s, w_fa2_c;
    logic [2:0] w_ones;
    logic       r_z_q;
    logic [2:0] r_ones_q;
    logic       r_out_valid;

    assign w_x = bus.x;

    // One AND term per 3-subset of the five inputs; any true term is a majority.
    assign w_terms[0] = w_x[0] & w_x[1] & w_x[2];
    assign w_terms[1] = w_x[0] & w_x[1] & w_x[3];
    assign w_terms[2] = w_x[0] & w_x[1] & w_x[4];
    assign w_terms[3] = w_x[0] & w_x[2] & w_x[3];
    assign w_terms[4] = w_x[0] & w_x[2] & w_x[4];
    assign w_terms[5] = w_x[0] & w_x[3] & w_x[4];
    assign w_terms[6] = w_x[1] & w_x[2] & w_x[3];
    assign w_terms[7] = w_x[1] & w_x[2] & w_x[4];
    assign w_terms[8] = w_x[1] & w_x[3] & w_x[4];
    assign w_terms[9] = w_x[2] & w_x[3] & w_x[4];
    assign w_z        = |w_terms;

    // Two full adders reduce to a weight-1 sum and two weight-2 carries.
    assign w_fa1_s   = w_x[0] ^ w_x[1] ^ w_x[2];
    assign w_fa1_c   = (w_x[0] & w_x[1]) | (w_x[2] & (w_x[0] ^ w_x[1]));
    assign w_fa2_s   = w_x[3] ^ w_x[4] ^ w_fa1_s;
    assign w_fa2_c   = (w_x[3] & w_x[4]) | (w_fa1_s & (w_x[3] ^ w_x[4]));
    assign w_ones[0] = w_fa2_s;
    assign w_ones[1] = w_fa1_c ^ w_fa2_c;
    assign w_ones[2] = w_fa1_c & w_fa2_c;

    assign bus.z    = w_z;
    assign bus.ones = w_ones;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z_q       <= 1'b0;
            r_ones_q    <= 3'd0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_z_q    <= w_z;
                r_ones_q <= w_ones;
            end
        end
    end

    assign bus.z_q       = r_z_q;
    assign bus.ones_q    = r_ones_q;
    assign bus.out_valid = r_out_valid;

`ifdef MAJORITY_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] r_maj_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_maj_cnt <= '0;
        end else if (bus.in_valid && w_z && (r_maj_cnt != CNT_MAX)) begin
            r_maj_cnt <= r_maj_cnt + CNT_W'(1);
        end
    end

    assign bus.maj_cnt = r_maj_cnt;
`else
    assign bus.maj_cnt = '0;
`endif
endmodule

// File: tb/tb_majority_ckt.sv
// Scoreboard bench for majority_ckt: a 16-bit and a 4-bit counter instance share
// the same stimulus; expectations come from a popcount/saturation model.
module tb_majority_ckt;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    majority_ckt_if #(.CNT_W(16)) bus16 ();
    majority_ckt_if #(.CNT_W(4))  bus4  ();

    majority_ckt #(.CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    majority_ckt #(.CNT_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    typedef struct {
        logic       z;
        logic [2:0] ones;
        int         c16;
        int         c4;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m16 = 0;
    int   m4  = 0;

    function automatic int popc(input logic [4:0] v);
        int n = 0;
        for (int i = 0; i < 5; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int cnt_exp(input int model);
`ifdef MAJORITY_CNT_EN
        return model;
`else
        return 0 * model;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [4:0] xv, input logic v);
        exp_t e;
        bus16.x = xv;  bus4.x = xv;
        bus16.in_valid = v;  bus4.in_valid = v;
        if (v) begin
            if (popc(xv) >= 3) begin
                if (m16 < 65535) m16++;
                if (m4 < 15) m4++;
            end
            e.z    = (popc(xv) >= 3);
            e.ones = 3'(popc(xv));
            e.c16  = cnt_exp(m16);
            e.c4   = cnt_exp(m4);
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input logic [4:0] xv, input logic v);
        @(posedge clk);
        #1;
        apply(xv, v);
    endtask

    // Monitor: pops an expectation whenever out_valid is seen, else checks hold.
    logic       h_z    = 1'b0;
    logic [2:0] h_ones = 3'd0;
    int         h_c16  = 0;
    int         h_c4   = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            h_z = 1'b0;  h_ones = 3'd0;  h_c16 = 0;  h_c4 = 0;
        end else if (bus16.out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                h_z = e.z;  h_ones = e.ones;  h_c16 = e.c16;  h_c4 = e.c4;
                check("sb_z_q",     32'(bus16.z_q),     32'(h_z));
                check("sb_ones_q",  32'(bus16.ones_q),  32'(h_ones));
                check("sb_cnt16",   32'(bus16.maj_cnt), 32'(h_c16));
                check("sb_cnt4",    32'(bus4.maj_cnt),  32'(h_c4));
                check("sb_valid4",  32'(bus4.out_valid), 32'd1);
            end
        end else begin
            check("hold_z_q",    32'(bus16.z_q),     32'(h_z));
            check("hold_ones_q", 32'(bus16.ones_q),  32'(h_ones));
            check("hold_cnt16",  32'(bus16.maj_cnt), 32'(h_c16));
            check("hold_cnt4",   32'(bus4.maj_cnt),  32'(h_c4));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] xv;
        apply(5'b10101, 1'b0);
        #2;
        check("rst_z",         32'(bus16.z),         32'd1);
        check("rst_ones",      32'(bus16.ones),      32'd3);
        check("rst_z_q",       32'(bus16.z_q),       32'd0);
        check("rst_ones_q",    32'(bus16.ones_q),    32'd0);
        check("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        check("rst_maj_cnt",   32'(bus16.maj_cnt),   32'd0);

        for (int i = 0; i < 32; i++) begin
            xv = 5'(i);
            bus16.x = xv;  bus4.x = xv;
            #1;
            check("comb_z",    32'(bus16.z),    32'(popc(xv) >= 3));
            check("comb_ones", 32'(bus16.ones), 32'(popc(xv)));
        end
        apply(5'b00000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Registered path and hold on invalid.
        step(5'b11010, 1'b1);
        step(5'b00001, 1'b0);
        @(negedge clk);
        check("reg_z_q",       32'(bus16.z_q),       32'd1);
        check("reg_ones_q",    32'(bus16.ones_q),    32'd3);
        check("reg_out_valid", 32'(bus16.out_valid), 32'd1);
        step(5'b00000, 1'b0);
        @(negedge clk);
        check("hold_z_q_direct", 32'(bus16.z_q),       32'd1);
        check("inv_out_valid",   32'(bus16.out_valid), 32'd0);

        // Reset mid-stream drops the pending valid sample.
        step(5'b11111, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        apply(5'b00000, 1'b0);
        m16 = 0;  m4 = 0;
        check("midrst_z_q",       32'(bus16.z_q),       32'd0);
        check("midrst_ones_q",    32'(bus16.ones_q),    32'd0);
        check("midrst_out_valid", 32'(bus16.out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Five majority votes interleaved with three minority votes.
        for (int i = 0; i < 8; i++)
            step((i % 3 == 1) ? 5'b00001 : 5'b11100, 1'b1);
        step(5'b00000, 1'b0);
        @(negedge clk);
        check("cnt_five", 32'(bus16.maj_cnt), 32'(cnt_exp(5)));

        // Saturation of the 4-bit counter.
        for (int i = 0; i < 20; i++) step(5'b11111, 1'b1);
        step(5'b00000, 1'b0);
        @(negedge clk);
        check("sat_cnt4", 32'(bus4.maj_cnt), 32'(cnt_exp(15)));
        step(5'b11111, 1'b1);
        step(5'b00000, 1'b0);
        @(negedge clk);
        check("sat_hold_cnt4", 32'(bus4.maj_cnt), 32'(cnt_exp(15)));
        check("sat_z_q4",      32'(bus4.z_q),     32'd1);
        check("sat_ones_q4",   32'(bus4.ones_q),  32'd5);

        for (int i = 0; i < 400; i++)
            step(5'($urandom), ($urandom_range(0, 3) != 0));
        step(5'b00000, 1'b0);
        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
